// File: rtl/dose_scheduler.sv
// Round-robin pill-compartment reminder sequencer with ack timeout and miss report.
// Optional snooze/retry stage is built when DOSE_SCHEDULER_SNOOZE_EN is defined.
module dose_scheduler #(
  parameter int N_SLOTS      = 4,
  parameter int SLOT_W       = 2,
  parameter int CNT_W        = 16,
  parameter int PRESCALE     = 100,
  parameter int ACK_TIMEOUT  = 50,
  parameter int SNOOZE_TICKS = 20,
  parameter int MAX_RETRY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [CNT_W-1:0]  cfg_interval,
  input  logic              cfg_enable,
  input  logic              ack,
  output logic              medicine_reminder,
  output logic [SLOT_W-1:0] reminder_slot,
  output logic              missed,
  output logic [SLOT_W-1:0] missed_slot,
  output logic [N_SLOTS-1:0] pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int T1 = (ACK_TIMEOUT > SNOOZE_TICKS) ? ACK_TIMEOUT : SNOOZE_TICKS;
  localparam int TMAX = (T1 > MAX_RETRY) ? T1 : MAX_RETRY;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REMIND = 2'd1;
`ifdef DOSE_SCHEDULER_SNOOZE_EN
  localparam logic [1:0] S_SNOOZE = 2'd2;
  logic [TW-1:0] rty_q, rty_d;
`endif

  logic [PW-1:0]      pre_q, pre_d;
  logic [1:0]         state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [SLOT_W-1:0]  ptr_q, ptr_d;
  logic               miss_q, miss_d;
  logic [SLOT_W-1:0]  mslot_q, mslot_d;
  logic [N_SLOTS-1:0] pend_q, pend_d;
  logic [N_SLOTS-1:0] en_q, en_d;
  logic [CNT_W-1:0]   rld_q [N_SLOTS];
  logic [CNT_W-1:0]   rld_d [N_SLOTS];
  logic [CNT_W-1:0]   cnt_q [N_SLOTS];
  logic [CNT_W-1:0]   cnt_d [N_SLOTS];

  logic               tick;
  logic               cfg_hit;
  logic               cfg_off;
  logic               act_off;
  logic [N_SLOTS-1:0] exp_v;
  logic [N_SLOTS-1:0] clr;
  logic               gnt_ok;
  logic [SLOT_W-1:0]  gnt;
  logic [SLOT_W-1:0]  idx;

  assign tick    = (pre_q == PW'(PRESCALE - 1));
  assign cfg_hit = cfg_we && (32'(cfg_slot) < N_SLOTS);
  assign cfg_off = cfg_hit && (!cfg_enable || cfg_interval == '0);
  assign act_off = cfg_off && (cfg_slot == slot_q) && (state_q != S_IDLE);

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    en_d    = en_q;
    rld_d   = rld_q;
    cnt_d   = cnt_q;
    exp_v   = '0;
    clr     = '0;
    state_d = state_q;
    tmr_d   = tmr_q;
    slot_d  = slot_q;
    ptr_d   = ptr_q;
    miss_d  = 1'b0;
    mslot_d = mslot_q;
    gnt_ok  = 1'b0;
    gnt     = '0;
    idx     = '0;
`ifdef DOSE_SCHEDULER_SNOOZE_EN
    rty_d   = rty_q;
`endif

    for (int i = 0; i < N_SLOTS; i++) begin
      if (cfg_hit && cfg_slot == SLOT_W'(i)) begin
        rld_d[i] = cfg_interval;
        cnt_d[i] = cfg_interval;
        en_d[i]  = cfg_enable;
      end else if (tick && en_q[i] && rld_q[i] != '0) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          exp_v[i] = 1'b1;
          cnt_d[i] = rld_q[i];
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
    if (cfg_off) clr[cfg_slot] = 1'b1;

    for (int k = 0; k < N_SLOTS; k++) begin
      idx = SLOT_W'((32'(ptr_q) + 32'(k)) % N_SLOTS);
      if (!gnt_ok && pend_q[idx]) begin
        gnt_ok = 1'b1;
        gnt    = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (gnt_ok) begin
          slot_d  = gnt;
          tmr_d   = TW'(ACK_TIMEOUT);
          state_d = S_REMIND;
          ptr_d   = (gnt == SLOT_W'(N_SLOTS - 1)) ? '0 : gnt + SLOT_W'(1);
`ifdef DOSE_SCHEDULER_SNOOZE_EN
          rty_d   = '0;
`endif
        end
      end
      S_REMIND: begin
        if (act_off) begin
          state_d = S_IDLE;
        end else if (ack) begin
          clr[slot_q] = 1'b1;
          state_d     = S_IDLE;
        end else if (tick) begin
          if (tmr_q > TW'(1)) begin
            tmr_d = tmr_q - TW'(1);
`ifdef DOSE_SCHEDULER_SNOOZE_EN
          end else if (rty_q < TW'(MAX_RETRY)) begin
            tmr_d   = TW'(SNOOZE_TICKS);
            state_d = S_SNOOZE;
`endif
          end else begin
            miss_d      = 1'b1;
            mslot_d     = slot_q;
            clr[slot_q] = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
`ifdef DOSE_SCHEDULER_SNOOZE_EN
      S_SNOOZE: begin
        if (act_off) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (tmr_q > TW'(1)) begin
            tmr_d = tmr_q - TW'(1);
          end else begin
            rty_d   = rty_q + TW'(1);
            tmr_d   = TW'(ACK_TIMEOUT);
            state_d = S_REMIND;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // a fresh expiry outranks any clear of the same slot
    pend_d = (pend_q & ~clr) | exp_v;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q   <= '0;
      state_q <= S_IDLE;
      tmr_q   <= '0;
      slot_q  <= '0;
      ptr_q   <= '0;
      miss_q  <= 1'b0;
      mslot_q <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        rld_q[i] <= '0;
        cnt_q[i] <= '0;
      end
`ifdef DOSE_SCHEDULER_SNOOZE_EN
      rty_q   <= '0;
`endif
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      miss_q  <= miss_d;
      mslot_q <= mslot_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      rld_q   <= rld_d;
      cnt_q   <= cnt_d;
`ifdef DOSE_SCHEDULER_SNOOZE_EN
      rty_q   <= rty_d;
`endif
    end
  end

  assign medicine_reminder = (state_q == S_REMIND);
  assign reminder_slot     = slot_q;
  assign missed            = miss_q;
  assign missed_slot       = mslot_q;
  assign pending           = pend_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler: intervals, ack, round-robin,
// timeout/miss, disable and reset, with PRESCALE=10.
module tb_dose_scheduler;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [15:0] cfg_interval;
  logic       cfg_enable;
  logic       ack;
  logic       medicine_reminder;
  logic [1:0] reminder_slot;
  logic       missed;
  logic [1:0] missed_slot;
  logic [3:0] pending;

  int checks = 0;
  int fails  = 0;
  logic [3:0] mpre;

  dose_scheduler #(
    .N_SLOTS(4), .SLOT_W(2), .CNT_W(16), .PRESCALE(10),
    .ACK_TIMEOUT(3), .SNOOZE_TICKS(2), .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_slot(cfg_slot),
    .cfg_interval(cfg_interval),
    .cfg_enable(cfg_enable),
    .ack(ack),
    .medicine_reminder(medicine_reminder),
    .reminder_slot(reminder_slot),
    .missed(missed),
    .missed_slot(missed_slot),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tick phase: a cycle is a tick cycle when mpre == 9
  always_ff @(posedge clk) begin
    if (!reset) mpre <= '0;
    else mpre <= (mpre == 4'd9) ? 4'd0 : mpre + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    int g = 0;
    while (k < n && g < 5000) begin
      @(negedge clk);
      g++;
      if (mpre == 4'd9) k++;
    end
    if (k < n) check("tick_wait", 32'(k), 32'(n));
  endtask

  task automatic wait_safe();
    int g = 0;
    while (mpre > 4'd5 && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic cfg(input logic [1:0] s, input logic [15:0] iv,
                     input logic en);
    cfg_we       = 1'b1;
    cfg_slot     = s;
    cfg_interval = iv;
    cfg_enable   = en;
    @(negedge clk);
    cfg_we       = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_slot = '0;
    cfg_interval = '0; cfg_enable = 1'b0; ack = 1'b0;
    step(); step();
    check("rst_rem",   32'(medicine_reminder), 32'd0);
    check("rst_rslot", 32'(reminder_slot),     32'd0);
    check("rst_miss",  32'(missed),            32'd0);
    check("rst_mslot", 32'(missed_slot),       32'd0);
    check("rst_pend",  32'(pending),           32'd0);
    reset = 1'b1;
    step();

    // basic interval of 5 ticks
    wait_safe();
    cfg(2'd0, 16'd5, 1'b1);
    wait_ticks(4);
    check("b_pend4", 32'(pending), 32'h0);
    wait_ticks(1);
    check("b_pend_t", 32'(pending), 32'h0);
    step();
    check("b_pend_t1", 32'(pending), 32'h1);
    check("b_rem_t1", 32'(medicine_reminder), 32'd0);
    step();
    check("b_rem_t2", 32'(medicine_reminder), 32'd1);
    check("b_slot_t2", 32'(reminder_slot), 32'd0);

    // acknowledge and next interval
    do_ack();
    check("a_rem", 32'(medicine_reminder), 32'd0);
    check("a_pend", 32'(pending), 32'h0);
    wait_ticks(5);
    check("a_pend_t", 32'(pending), 32'h0);
    step();
    check("a_pend_t1", 32'(pending), 32'h1);
    step();
    check("a_rem_t2", 32'(medicine_reminder), 32'd1);
    do_ack();
    cfg(2'd0, 16'd0, 1'b0);
    check("a_off_pend", 32'(pending), 32'h0);

    // round-robin over slots 1 and 3
    wait_safe();
    cfg(2'd1, 16'd3, 1'b1);
    cfg(2'd3, 16'd3, 1'b1);
    for (int r = 0; r < 2; r++) begin
      wait_ticks(3);
      step();
      check("rr_pend", 32'(pending), 32'ha);
      step();
      check("rr_rem1", 32'(medicine_reminder), 32'd1);
      check("rr_slot1", 32'(reminder_slot), 32'd1);
      do_ack();
      check("rr_gap", 32'(medicine_reminder), 32'd0);
      check("rr_pend3", 32'(pending), 32'h8);
      step();
      check("rr_rem3", 32'(medicine_reminder), 32'd1);
      check("rr_slot3", 32'(reminder_slot), 32'd3);
      do_ack();
      check("rr_pend0", 32'(pending), 32'h0);
    end
    cfg(2'd1, 16'd0, 1'b0);
    cfg(2'd3, 16'd0, 1'b1);

    // timeout and miss on slot 2
    wait_safe();
    cfg(2'd2, 16'd4, 1'b1);
    wait_ticks(4);
    step(); step();
    check("m_rem", 32'(medicine_reminder), 32'd1);
    check("m_slot", 32'(reminder_slot), 32'd2);
`ifdef DOSE_SCHEDULER_SNOOZE_EN
    for (int w = 0; w < 2; w++) begin
      wait_ticks(3);
      check("s_rem_end", 32'(medicine_reminder), 32'd1);
      step();
      check("s_snooze", 32'(medicine_reminder), 32'd0);
      check("s_nomiss", 32'(missed), 32'd0);
      wait_ticks(2);
      check("s_snz_end", 32'(medicine_reminder), 32'd0);
      step();
      check("s_rerem", 32'(medicine_reminder), 32'd1);
    end
`endif
    wait_ticks(3);
    check("m_rem_end", 32'(medicine_reminder), 32'd1);
    check("m_pre", 32'(missed), 32'd0);
    step();
    check("m_pulse", 32'(missed), 32'd1);
    check("m_mslot", 32'(missed_slot), 32'd2);
    check("m_rem_off", 32'(medicine_reminder), 32'd0);
    check("m_pend", 32'(pending), 32'h0);
    step();
    check("m_pulse_end", 32'(missed), 32'd0);
    cfg(2'd2, 16'd0, 1'b0);

    // disable mid-reminder
    wait_safe();
    cfg(2'd0, 16'd2, 1'b1);
    wait_ticks(2);
    step(); step();
    check("d_rem", 32'(medicine_reminder), 32'd1);
    check("d_slot", 32'(reminder_slot), 32'd0);
    cfg(2'd0, 16'd2, 1'b0);
    check("d_rem_off", 32'(medicine_reminder), 32'd0);
    check("d_pend", 32'(pending), 32'h0);
    check("d_miss", 32'(missed), 32'd0);
    step();
    check("d_miss2", 32'(missed), 32'd0);
    wait_ticks(3);
    check("d_quiet", 32'(pending), 32'h0);

    // reset while reminding
    wait_safe();
    cfg(2'd1, 16'd2, 1'b1);
    wait_ticks(2);
    step(); step();
    check("r_rem", 32'(medicine_reminder), 32'd1);
    check("r_slot", 32'(reminder_slot), 32'd1);
    check("r_mslot", 32'(missed_slot), 32'd2);
    reset = 1'b0;
    step();
    check("r_rem0", 32'(medicine_reminder), 32'd0);
    check("r_slot0", 32'(reminder_slot), 32'd0);
    check("r_miss0", 32'(missed), 32'd0);
    check("r_mslot0", 32'(missed_slot), 32'd0);
    check("r_pend0", 32'(pending), 32'h0);
    reset = 1'b1;
    wait_ticks(5);
    check("r_idle_rem", 32'(medicine_reminder), 32'd0);
    check("r_idle_pend", 32'(pending), 32'h0);
    check("r_idle_miss", 32'(missed), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
